// File: rtl/winograd_pkg.sv
// Shared Winograd F(4x4,3x3) parameters, tile types and output-transform FSM states.
package winograd_pkg;

    localparam int DATA_W   = 32;
    localparam int OUT_M    = 4;
    localparam int KERNEL_R = 3;
    localparam int TILE_N   = OUT_M + KERNEL_R - 1;

    typedef logic [DATA_W-1:0] word_t;
    typedef word_t [0:TILE_N-1][0:TILE_N-1] in_tile_t;
    typedef word_t [0:OUT_M-1][0:OUT_M-1]   out_tile_t;
    typedef word_t [0:OUT_M-1][0:TILE_N-1]  mid_tile_t;
    typedef word_t [0:TILE_N-1]             vec_in_t;
    typedef word_t [0:OUT_M-1]              vec_out_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS1 = 2'd1,
        PASS2 = 2'd2,
        DONE  = 2'd3
    } otu_state_t;

endpackage

// File: rtl/winograd_output_transform_1d.sv
// Combinational 1D output transform (A^T * d) for F(4,3); all arithmetic wraps modulo 2^32.
module winograd_output_transform_1d
    import winograd_pkg::*;
(
    input  vec_in_t  d,
    output vec_out_t o
);

    word_t diff34;
    word_t sum34;

    always_comb begin
        diff34 = d[3] - d[4];
        sum34  = d[3] + d[4];
        o[0]   = d[0] + d[1] + d[2] + d[3] + d[4];
        o[1]   = d[1] - d[2] + (diff34 << 1);
        o[2]   = d[1] + d[2] + (sum34 << 2);
        o[3]   = d[1] - d[2] + (diff34 << 3) + d[5];
    end

endmodule

// File: rtl/output_transform_unit.sv
// Winograd 6x6 -> 4x4 output transform: column pass into T, then row pass into tile_out.
// Build option: define OTU_RELU_EN to clamp negative row-pass results to zero.
module output_transform_unit
    import winograd_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      start,
    input  in_tile_t  tile_in,
    output out_tile_t tile_out,
    output logic      busy,
    output logic      transform_done
);

    // state | meaning
    // IDLE  | waiting for start; captures tile_in on start
    // PASS1 | column idx (0..5) of captured tile -> column idx of T
    // PASS2 | row idx (0..3) of T -> row idx of tile_out
    // DONE  | raise transform_done for one cycle, return to IDLE

    otu_state_t state;
    logic [2:0] idx;
    in_tile_t   cap;
    mid_tile_t  t_reg;
    vec_in_t    tf_in;
    vec_out_t   tf_out;
    vec_out_t   row_res;

    // One transform instance shared by both passes; state selects its operand.
    always_comb begin
        tf_in = '0;
        if (state == PASS2) begin
            for (int i = 0; i < OUT_M; i++) begin
                if (idx == 3'(i)) begin
                    for (int c = 0; c < TILE_N; c++) tf_in[c] = t_reg[i][c];
                end
            end
        end else begin
            for (int c = 0; c < TILE_N; c++) begin
                if (idx == 3'(c)) begin
                    for (int r = 0; r < TILE_N; r++) tf_in[r] = cap[r][c];
                end
            end
        end
    end

    winograd_output_transform_1d u_tf (
        .d (tf_in),
        .o (tf_out)
    );

    always_comb begin
        for (int k = 0; k < OUT_M; k++) begin
`ifdef OTU_RELU_EN
            row_res[k] = tf_out[k][DATA_W-1] ? '0 : tf_out[k];
`else
            row_res[k] = tf_out[k];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            idx            <= '0;
            cap            <= '0;
            t_reg          <= '0;
            tile_out       <= '0;
            busy           <= 1'b0;
            transform_done <= 1'b0;
        end else begin
            transform_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cap   <= tile_in;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= PASS1;
                    end
                end
                PASS1: begin
                    for (int c = 0; c < TILE_N; c++) begin
                        if (idx == 3'(c)) begin
                            for (int k = 0; k < OUT_M; k++) t_reg[k][c] <= tf_out[k];
                        end
                    end
                    if (idx == 3'(TILE_N - 1)) begin
                        idx   <= '0;
                        state <= PASS2;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                PASS2: begin
                    for (int i = 0; i < OUT_M; i++) begin
                        if (idx == 3'(i)) begin
                            for (int k = 0; k < OUT_M; k++) tile_out[i][k] <= row_res[k];
                        end
                    end
                    if (idx == 3'(OUT_M - 1)) begin
                        idx   <= '0;
                        state <= DONE;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                DONE: begin
                    transform_done <= 1'b1;
                    busy           <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
